ahb_sram_slave: RTL and testbench

AHB-Lite SRAM slave: word-organised on-chip memory that consumes the address/control/write-data phases driven by the team's AHB-Lite master and returns HRDATA, HREADYOUT and HRESP. It sits directly downstream of the master, behind the HSELx decode, with one HSEL bit per slave instance. Supports byte, halfword and word transfers, the two-cycle ERROR response and optional wait-state insertion.

---
 rtl/ahb_pkg.sv | 34 +++
 rtl/ahb_byte_strobe.sv | 35 +++
 rtl/ahb_sram_slave.sv | 176 +++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings shared by the master and its slaves,
// plus the state type of the SRAM slave FSM.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } sram_state_e;

endpackage

// File: rtl/ahb_byte_strobe.sv
// ahb_byte_strobe: size/offset -> little-endian lane enables.
// Ports: size, addr in; strb, size_err, align_err out.
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr,
  output logic [3:0] strb,
  output logic       size_err,
  output logic       align_err
);

  always_comb begin
    strb      = 4'b0000;
    size_err  = 1'b0;
    align_err = 1'b0;
    unique case (1'b1)
      size == HSIZE_BYTE: begin
        strb = 4'b0001 << addr;
      end
      size == HSIZE_HALF: begin
        align_err = addr[0];
        strb      = addr[1] ? 4'b1100 : 4'b0011;
      end
      size == HSIZE_WORD: begin
        align_err = |addr;
        strb      = 4'b1111;
      end
      default: begin
        size_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite word SRAM with ERROR response; wait states
// when AHB_SRAM_WAIT_EN is defined. Ports: HCLK, HRESETn, HSEL, HADDR,
// HTRANS, HWRITE, HSIZE, HWDATA, HREADY in; HREADYOUT, HRESP, HRDATA out.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  sram_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] hidx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  wr_q;
  logic [3:0]            strb_q;
  logic [3:0]            strb;
  logic                  size_err;
  logic                  align_err;
  logic                  range_err;
  logic                  bad;
  logic                  acc_ok;
  logic                  we;
  logic                  rd_go;
  logic                  hreadyout_q;
  logic                  hresp_q;
  logic [31:0]           rdata_q;
  logic [31:0]           rd_word;
  logic                  unused_ok;

  assign hidx      = HADDR[ADDR_WIDTH+1:2];
  assign range_err = |(HADDR >> (ADDR_WIDTH + 2));

  ahb_byte_strobe u_strb (
    .size      (HSIZE),
    .addr      (HADDR[1:0]),
    .strb      (strb),
    .size_err  (size_err),
    .align_err (align_err)
  );

  assign bad = size_err | align_err | range_err;

  // WAIT and ERR1 hold the bus, so no new address phase is taken there.
  assign acc_ok = HSEL & HREADY & HTRANS[1]
                & (state_q != ST_WAIT)
                & (state_q != ST_ERR1);

  assign we = (state_q == ST_DATA) & wr_q;

`ifdef AHB_SRAM_WAIT_EN
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [3:0] cnt_q, cnt_d;

  assign rd_idx = (state_q == ST_WAIT) ? addr_q : hidx;
  assign rd_go  = (state_d == ST_DATA)
                & ((state_q == ST_WAIT) ? !wr_q : !HWRITE);
  assign unused_ok = HTRANS[0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign rd_idx    = hidx;
  assign rd_go     = (state_d == ST_DATA) & !HWRITE;
  assign unused_ok = HTRANS[0] ^ (WAIT_STATES != 0);
`endif

  always_comb begin
    state_d = state_q;
`ifdef AHB_SRAM_WAIT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
`ifdef AHB_SRAM_WAIT_EN
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_DATA;
        end
      end
`endif
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
        if (acc_ok) begin
          if (bad) begin
            state_d = ST_ERR1;
          end else begin
`ifdef AHB_SRAM_WAIT_EN
            state_d = ST_WAIT;
            cnt_d   = WS;
`else
            state_d = ST_DATA;
`endif
          end
        end
      end
    endcase
  end

  // A write completing this edge is merged in so a chained read of
  // the same word sees the new data without a stall.
  always_comb begin
    rd_word = mem[rd_idx];
    for (int i = 0; i < 4; i++) begin
      if (we && strb_q[i] && (addr_q == rd_idx)) begin
        rd_word[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      strb_q      <= 4'b0000;
      rdata_q     <= 32'h0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= (state_d != ST_WAIT) && (state_d != ST_ERR1);
      hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
      rdata_q     <= rd_go ? rd_word : 32'h0;
      if (acc_ok) begin
        addr_q <= hidx;
        wr_q   <= HWRITE & !bad;
        strb_q <= strb;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) begin
          mem[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed + random AHB-Lite traffic against a
// transfer-level memory model of the SRAM slave.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

`ifdef AHB_SRAM_WAIT_EN
  localparam int WS = 2;
`else
  localparam int WS = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'h0;
  logic [1:0]  HTRANS = 2'd0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd0;
  logic [31:0] HWDATA = 32'h0;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(
    .ADDR_WIDTH  (8),
    .WAIT_STATES (2)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [2:0]  s;
    logic [31:0] d;
    logic [1:0]  t;
  } xf_t;

  int          checks = 0;
  int          errors = 0;
  xf_t         q[$];
  logic [31:0] mw [256];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  function automatic xf_t mk(logic w, logic [31:0] a, logic [2:0] s,
                             logic [31:0] d, logic [1:0] t);
    xf_t x;
    x.w = w;
    x.a = a;
    x.s = s;
    x.d = d;
    x.t = t;
    return x;
  endfunction

  function automatic bit is_err(xf_t x);
    if (x.s > 3'd2) return 1'b1;
    if ((x.a % (32'd1 << x.s)) != 0) return 1'b1;
    return x.a >= 32'h400;
  endfunction

  function automatic void commit(xf_t x);
    int n;
    int base;
    if (!x.w || is_err(x)) return;
    n = 1 << x.s;
    base = int'(x.a % 4);
    for (int b = 0; b < n; b++) begin
      mw[x.a / 4][8*(base+b) +: 8] = x.d[8*(base+b) +: 8];
    end
  endfunction

  task automatic idle_chk(input string tag);
    chk1({tag, "_rdy"}, HREADYOUT, 1'b1);
    chk1({tag, "_resp"}, HRESP, 1'b0);
    chk({tag, "_rdata"}, HRDATA, 32'h0);
  endtask

  task automatic dp_chk(input xf_t x, input int c);
    logic [31:0] rd;
    logic        rdy;
    logic        rsp;
    string       tg;
    rd = 32'h0;
    tg = $sformatf("%s@%h s%0d c%0d", x.w ? "wr" : "rd", x.a, x.s, c);
    if (is_err(x)) begin
      rdy = (c == 1);
      rsp = 1'b1;
    end else begin
      rdy = (c == WS);
      rsp = 1'b0;
      if (rdy && !x.w) rd = mw[x.a / 4];
    end
    chk1({tg, " rdy"}, HREADYOUT, rdy);
    chk1({tg, " resp"}, HRESP, rsp);
    chk({tg, " rdata"}, HRDATA, rd);
  endtask

  // Issue every queued transfer back to back, pipelining the next
  // address phase under the current data phase.
  task automatic run_q();
    int i = 0;
    int dp = -1;
    int c = 0;
    int last = 0;
    HSEL = 1'b1;
    while (i < q.size() || dp >= 0) begin
      if (i < q.size()) begin
        HTRANS = q[i].t;
        HADDR  = q[i].a;
        HWRITE = q[i].w;
        HSIZE  = q[i].s;
      end else begin
        HTRANS = HTRANS_IDLE;
      end
      HWDATA = (dp >= 0) ? q[dp].d : 32'h0;
      @(negedge HCLK);
      if (dp >= 0) dp_chk(q[dp], c);
      else idle_chk("pre");
      @(posedge HCLK);
      if (dp < 0 || c == last) begin
        if (dp >= 0) commit(q[dp]);
        if (i < q.size()) begin
          dp = i;
          i++;
          c = 0;
          last = is_err(q[dp]) ? 1 : WS;
        end else begin
          dp = -1;
        end
      end else begin
        c++;
      end
      #1;
    end
    q.delete();
  endtask

  task automatic idle(input int n);
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    repeat (n) begin
      @(negedge HCLK);
      idle_chk("idle");
      @(posedge HCLK);
      #1;
    end
  endtask

  xf_t x;
  int  n;

  initial begin
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    idle_chk("reset");
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    for (int k = 0; k < 256; k++) begin
      q.push_back(mk(1'b1, 32'(k * 4), HSIZE_WORD, $urandom,
                     (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ));
    end
    run_q();

    q.push_back(mk(1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, HTRANS_NONSEQ));
    run_q();
    q.push_back(mk(1'b0, 32'h10, HSIZE_WORD, 32'h0, HTRANS_NONSEQ));
    run_q();

    q.push_back(mk(1'b1, 32'h10, HSIZE_WORD, 32'h11223344, HTRANS_NONSEQ));
    q.push_back(mk(1'b1, 32'h13, HSIZE_BYTE, 32'hAA000000, HTRANS_SEQ));
    q.push_back(mk(1'b0, 32'h10, HSIZE_WORD, 32'h0, HTRANS_SEQ));
    q.push_back(mk(1'b1, 32'h12, HSIZE_HALF, 32'hBEEF0000, HTRANS_SEQ));
    q.push_back(mk(1'b0, 32'h10, HSIZE_WORD, 32'h0, HTRANS_SEQ));
    run_q();

    q.push_back(mk(1'b1, 32'h02, HSIZE_WORD, 32'hFFFFFFFF, HTRANS_NONSEQ));
    q.push_back(mk(1'b0, 32'h00, HSIZE_WORD, 32'h0, HTRANS_SEQ));
    q.push_back(mk(1'b1, 32'h400, HSIZE_WORD, 32'h12345678, HTRANS_NONSEQ));
    q.push_back(mk(1'b0, 32'h00, HSIZE_WORD, 32'h0, HTRANS_SEQ));
    run_q();

    q.push_back(mk(1'b0, 32'h0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ));
    q.push_back(mk(1'b0, 32'h4, HSIZE_WORD, 32'h0, HTRANS_SEQ));
    run_q();

    HSEL   = 1'b1;
    HTRANS = HTRANS_BUSY;
    HWRITE = 1'b1;
    HADDR  = 32'h30;
    HSIZE  = HSIZE_WORD;
    HWDATA = 32'hFFFF0000;
    @(negedge HCLK);
    idle_chk("busy");
    @(posedge HCLK);
    #1;
    HSEL   = 1'b0;
    HTRANS = HTRANS_NONSEQ;
    HWDATA = 32'h0000FFFF;
    @(negedge HCLK);
    idle_chk("nosel");
    @(posedge HCLK);
    #1;
    HSEL   = 1'b1;
    HTRANS = HTRANS_IDLE;
    HWDATA = 32'hA5A5A5A5;
    @(negedge HCLK);
    idle_chk("nosel_after");
    @(posedge HCLK);
    #1;
    q.push_back(mk(1'b0, 32'h30, HSIZE_WORD, 32'h0, HTRANS_NONSEQ));
    run_q();

    HSEL   = 1'b1;
    HTRANS = HTRANS_NONSEQ;
    HWRITE = 1'b1;
    HADDR  = 32'h20;
    HSIZE  = HSIZE_WORD;
    @(posedge HCLK);
    #1;
    HTRANS = HTRANS_IDLE;
    HWDATA = 32'h5A5A5A5A;
    chk1("pre_rst_rdy", HREADYOUT, WS == 0);
    HRESETn = 1'b0;
    #1;
    idle_chk("midrst");
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    q.push_back(mk(1'b0, 32'h20, HSIZE_WORD, 32'h0, HTRANS_NONSEQ));
    run_q();

    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        x.w = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 19) == 0) x.s = 3'($urandom_range(3, 7));
        else x.s = 3'($urandom_range(0, 2));
        x.a = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 4) != 0 && x.s <= 3'd2) begin
          x.a = x.a & ~((32'd1 << x.s) - 32'd1);
        end
        if ($urandom_range(0, 14) == 0) begin
          x.a = x.a | (32'd1 << $urandom_range(10, 31));
        end
        x.d = $urandom;
        x.t = (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        q.push_back(x);
      end
      run_q();
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
